// File: rtl/merger_pkg.sv
// Shared constants and types for the merger tree's leaf-refill logic.
package merger_pkg;

    localparam int unsigned NUM_LEAVES = 32;
    localparam int unsigned LEAF_W     = 5;
    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned BURST      = 8;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned LEN_W      = 32;

    localparam int unsigned CREDIT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BEATS_W  = $clog2(BURST) + 1;
    // Sized for every leaf holding a full FIFO's worth of requested items.
    localparam int unsigned OUTST_W  = 16;

    typedef logic [LEAF_W-1:0] leaf_idx_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
    } run_desc_t;

    function automatic logic [BEATS_W-1:0] beats_of(input logic [LEN_W-1:0] len);
        if (len >= LEN_W'(BURST)) begin
            return BEATS_W'(BURST);
        end
        return BEATS_W'(len);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 32,
    parameter int unsigned IDX_W   = 5
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W:0] cand;
    logic           found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!found && req[cand[IDX_W-1:0]]) begin
                found                    = 1'b1;
                grant[cand[IDX_W-1:0]]   = 1'b1;
                grant_idx                = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/leaf_refill_scheduler.sv
// Schedules burst refills of the leaf input FIFOs from per-leaf run descriptors,
// using per-leaf credits and round-robin arbitration onto one read-request port.
module leaf_refill_scheduler
    import merger_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cfg_we,
    input  logic [LEAF_W-1:0]     i_cfg_leaf,
    input  logic [ADDR_W-1:0]     i_cfg_addr,
    input  logic [LEN_W-1:0]      i_cfg_len,
    input  logic                  i_start,
    input  logic [NUM_LEAVES-1:0] i_leaf_read,
    output logic                  o_req_valid,
    input  logic                  i_req_ready,
    output logic [ADDR_W-1:0]     o_req_addr,
    output logic [LEAF_W-1:0]     o_req_leaf,
    output logic [BEATS_W-1:0]    o_req_beats,
    input  logic                  i_resp_valid,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]          state_q, state_d;
    run_desc_t           desc_q   [NUM_LEAVES];
    run_desc_t           desc_d   [NUM_LEAVES];
    logic [CREDIT_W-1:0] credit_q [NUM_LEAVES];
    logic [CREDIT_W-1:0] credit_d [NUM_LEAVES];
    logic [OUTST_W-1:0]  outst_q, outst_d;
    leaf_idx_t           rr_q, rr_d;
    logic                err_q, err_d;

    logic                req_valid_q, req_valid_d;
    logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
    leaf_idx_t           req_leaf_q, req_leaf_d;
    logic [BEATS_W-1:0]  req_beats_q, req_beats_d;

    logic                  accept;
    logic                  issue_ok;
    logic                  all_empty;
    logic [NUM_LEAVES-1:0] eligible;
    logic [NUM_LEAVES-1:0] grant;
    leaf_idx_t             grant_idx;

    assign accept   = req_valid_q & i_req_ready;
    // A new request may be registered whenever the request slot is free next cycle.
    assign issue_ok = (state_q == ST_RUN) & (~req_valid_q | i_req_ready);

    always_comb begin
        all_empty = 1'b1;
        for (int l = 0; l < NUM_LEAVES; l++) begin
            if (desc_q[l].len != '0) begin
                all_empty = 1'b0;
            end
        end
    end

    // Descriptor and credit next-state; eligibility is judged on these so a
    // grant can be registered in the same cycle as the previous acceptance.
    always_comb begin
        desc_d   = desc_q;
        credit_d = credit_q;
        for (int l = 0; l < NUM_LEAVES; l++) begin
            if (i_leaf_read[l] && credit_q[l] != CREDIT_W'(FIFO_DEPTH)) begin
                credit_d[l] = credit_q[l] + CREDIT_W'(1);
            end
        end
        if (accept) begin
            desc_d[req_leaf_q].addr = desc_q[req_leaf_q].addr + ADDR_W'(req_beats_q);
            desc_d[req_leaf_q].len  = desc_q[req_leaf_q].len - LEN_W'(req_beats_q);
            credit_d[req_leaf_q]    = credit_d[req_leaf_q] - CREDIT_W'(req_beats_q);
        end
        if (state_q == ST_IDLE && i_cfg_we) begin
            desc_d[i_cfg_leaf].addr = i_cfg_addr;
            desc_d[i_cfg_leaf].len  = i_cfg_len;
        end
        for (int l = 0; l < NUM_LEAVES; l++) begin
            eligible[l] = (desc_d[l].len != '0) &&
                          (credit_d[l] >= CREDIT_W'(beats_of(desc_d[l].len)));
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (accept) begin
            rr_d = (req_leaf_q == leaf_idx_t'(NUM_LEAVES - 1)) ? '0
                                                               : req_leaf_q + leaf_idx_t'(1);
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_LEAVES),
        .IDX_W   (LEAF_W)
    ) u_rr_arbiter (
        .req       (eligible),
        .ptr       (rr_d),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        req_valid_d = req_valid_q & ~i_req_ready;
        req_addr_d  = req_addr_q;
        req_leaf_d  = req_leaf_q;
        req_beats_d = req_beats_q;
        if (issue_ok && (|grant)) begin
            req_valid_d = 1'b1;
            req_addr_d  = desc_d[grant_idx].addr;
            req_leaf_d  = grant_idx;
            req_beats_d = beats_of(desc_d[grant_idx].len);
        end
    end

    always_comb begin
        outst_d = outst_q;
        err_d   = err_q;
        if (accept) begin
            outst_d = outst_d + OUTST_W'(req_beats_q);
        end
        if (i_resp_valid) begin
            if (outst_q == '0) begin
                err_d = 1'b1;
            end else begin
                outst_d = outst_d - OUTST_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (i_start) state_d = all_empty ? ST_DONE : ST_RUN;
            ST_RUN:   if (all_empty && !req_valid_q) state_d = ST_DRAIN;
            ST_DRAIN: if (outst_q == '0) state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            outst_q     <= '0;
            rr_q        <= '0;
            err_q       <= 1'b0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_leaf_q  <= '0;
            req_beats_q <= '0;
            for (int l = 0; l < NUM_LEAVES; l++) begin
                desc_q[l]   <= '0;
                credit_q[l] <= CREDIT_W'(FIFO_DEPTH);
            end
        end else begin
            state_q     <= state_d;
            outst_q     <= outst_d;
            rr_q        <= rr_d;
            err_q       <= err_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            req_leaf_q  <= req_leaf_d;
            req_beats_q <= req_beats_d;
            for (int l = 0; l < NUM_LEAVES; l++) begin
                desc_q[l]   <= desc_d[l];
                credit_q[l] <= credit_d[l];
            end
        end
    end

    assign o_req_valid = req_valid_q;
    assign o_req_addr  = req_addr_q;
    assign o_req_leaf  = req_leaf_q;
    assign o_req_beats = req_beats_q;
    assign o_busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign o_done      = (state_q == ST_DONE);
    assign o_err       = err_q;

endmodule

// File: tb/tb_leaf_refill_scheduler.sv
// Directed self-checking bench for leaf_refill_scheduler.
module tb_leaf_refill_scheduler;

    logic        clk;
    logic        rst;
    logic        cfg_we;
    logic [4:0]  cfg_leaf;
    logic [31:0] cfg_addr;
    logic [31:0] cfg_len;
    logic        start;
    logic [31:0] leaf_read;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [4:0]  req_leaf;
    logic [3:0]  req_beats;
    logic        resp_valid;
    logic        busy;
    logic        done;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    leaf_refill_scheduler dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_cfg_we     (cfg_we),
        .i_cfg_leaf   (cfg_leaf),
        .i_cfg_addr   (cfg_addr),
        .i_cfg_len    (cfg_len),
        .i_start      (start),
        .i_leaf_read  (leaf_read),
        .o_req_valid  (req_valid),
        .i_req_ready  (req_ready),
        .o_req_addr   (req_addr),
        .o_req_leaf   (req_leaf),
        .o_req_beats  (req_beats),
        .i_resp_valid (resp_valid),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_req(input string tag, input logic [31:0] addr, input logic [4:0] leaf,
                             input logic [3:0] beats);
        check({tag, ".valid"}, 64'(req_valid), 64'd1);
        check({tag, ".addr"}, 64'(req_addr), 64'(addr));
        check({tag, ".leaf"}, 64'(req_leaf), 64'(leaf));
        check({tag, ".beats"}, 64'(req_beats), 64'(beats));
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        cfg_we     = 1'b0;
        cfg_leaf   = '0;
        cfg_addr   = '0;
        cfg_len    = '0;
        start      = 1'b0;
        leaf_read  = '0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic cfg(input logic [4:0] leaf, input logic [31:0] addr, input logic [31:0] len);
        cfg_we   = 1'b1;
        cfg_leaf = leaf;
        cfg_addr = addr;
        cfg_len  = len;
        cycle();
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic responses(input int n);
        resp_valid = 1'b1;
        repeat (n) cycle();
        resp_valid = 1'b0;
    endtask

    // Counts o_done pulses over a bounded window; exactly one is required.
    task automatic wait_done(input string tag, input int max_cycles);
        int pulses = 0;
        for (int i = 0; i < max_cycles; i++) begin
            if (done) pulses++;
            cycle();
        end
        check({tag, ".done_pulses"}, 64'(pulses), 64'd1);
        check({tag, ".busy_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        do_reset();
        check("reset.valid", 64'(req_valid), 64'd0);
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.done", 64'(done), 64'd0);
        check("reset.err", 64'(err), 64'd0);
        check("reset.addr", 64'(req_addr), 64'd0);
        check("reset.beats", 64'(req_beats), 64'd0);

        // Single leaf: run of 20 issues 8, 8, stall on credit, then 4.
        cfg(5'd3, 32'h100, 32'd20);
        req_ready = 1'b1;
        pulse_start();
        check("single.busy", 64'(busy), 64'd1);
        check("single.first_latency", 64'(req_valid), 64'd0);
        cycle();
        check_req("single.r0", 32'h100, 5'd3, 4'd8);
        cycle();
        check_req("single.r1", 32'h108, 5'd3, 4'd8);
        cycle();
        check("single.stall0", 64'(req_valid), 64'd0);
        repeat (3) cycle();
        check("single.stall1", 64'(req_valid), 64'd0);
        leaf_read = 32'h1 << 3;
        repeat (4) cycle();
        leaf_read = '0;
        check_req("single.r2", 32'h110, 5'd3, 4'd4);
        cycle();
        check("single.after_last", 64'(req_valid), 64'd0);
        responses(20);
        check("single.err", 64'(err), 64'd0);
        wait_done("single", 5);

        // Round robin across 0, 5, 31 on consecutive cycles, pointer wraps.
        do_reset();
        cfg(5'd0, 32'h1000, 32'd8);
        cfg(5'd5, 32'h2000, 32'd8);
        cfg(5'd31, 32'h3000, 32'd8);
        req_ready = 1'b1;
        pulse_start();
        cycle();
        check_req("rr.g0", 32'h1000, 5'd0, 4'd8);
        cycle();
        check_req("rr.g1", 32'h2000, 5'd5, 4'd8);
        cycle();
        check_req("rr.g2", 32'h3000, 5'd31, 4'd8);
        cycle();
        check("rr.idle", 64'(req_valid), 64'd0);
        check("rr.ptr_wrap", 64'(dut.rr_q), 64'd0);
        responses(24);
        wait_done("rr", 5);

        // Backpressure then a simultaneous accept/read/response on leaf 2.
        do_reset();
        cfg(5'd2, 32'h200, 32'd16);
        pulse_start();
        cycle();
        check_req("bp.rise", 32'h200, 5'd2, 4'd8);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_req("bp.hold", 32'h200, 5'd2, 4'd8);
        end
        req_ready = 1'b1;
        cycle();
        req_ready = 1'b0;
        check_req("bp.next", 32'h208, 5'd2, 4'd8);
        check("bp.one_accept_len", 64'(dut.desc_q[2].len), 64'd8);
        check("sim.credit_before", 64'(dut.credit_q[2]), 64'd8);
        check("sim.outst_before", 64'(dut.outst_q), 64'd8);
        req_ready  = 1'b1;
        leaf_read  = 32'h1 << 2;
        resp_valid = 1'b1;
        cycle();
        req_ready  = 1'b0;
        leaf_read  = '0;
        resp_valid = 1'b0;
        check("sim.credit_after", 64'(dut.credit_q[2]), 64'd1);
        check("sim.outst_after", 64'(dut.outst_q), 64'd15);
        check("sim.no_more_req", 64'(req_valid), 64'd0);
        responses(15);
        check("sim.err", 64'(err), 64'd0);
        wait_done("sim", 5);

        // Config write and start during RUN must be ignored.
        do_reset();
        cfg(5'd7, 32'h700, 32'd8);
        pulse_start();
        cfg_we   = 1'b1;
        cfg_leaf = 5'd7;
        cfg_addr = 32'hdead;
        cfg_len  = 32'd3;
        start    = 1'b1;
        cycle();
        cfg_we = 1'b0;
        start  = 1'b0;
        check_req("ign.req", 32'h700, 5'd7, 4'd8);
        check("ign.desc_addr", 64'(dut.desc_q[7].addr), 64'h700);
        req_ready = 1'b1;
        cycle();
        req_ready = 1'b0;
        check("ign.desc_addr_after", 64'(dut.desc_q[7].addr), 64'h708);
        check("ign.desc_len_after", 64'(dut.desc_q[7].len), 64'd0);
        responses(8);
        wait_done("ign", 5);

        // Empty pass: done within 2 cycles, no request ever.
        do_reset();
        begin
            int pulses = 0;
            int reqs   = 0;
            pulse_start();
            for (int i = 0; i < 2; i++) begin
                if (done) pulses++;
                if (req_valid) reqs++;
                cycle();
            end
            check("empty.done_pulses", 64'(pulses), 64'd1);
            check("empty.no_req", 64'(reqs), 64'd0);
        end

        // Response in IDLE is an error, and sticky.
        resp_valid = 1'b1;
        cycle();
        resp_valid = 1'b0;
        check("err.idle_resp", 64'(err), 64'd1);
        cycle();
        check("err.sticky", 64'(err), 64'd1);

        // Reset mid-pass clears everything; a late response then flags an error.
        cfg(5'd1, 32'h40, 32'd8);
        pulse_start();
        cycle();
        check("midrst.valid_before", 64'(req_valid), 64'd1);
        check("midrst.busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("midrst.valid", 64'(req_valid), 64'd0);
        check("midrst.busy", 64'(busy), 64'd0);
        check("midrst.done", 64'(done), 64'd0);
        check("midrst.err", 64'(err), 64'd0);
        check("midrst.addr", 64'(req_addr), 64'd0);
        check("midrst.leaf", 64'(req_leaf), 64'd0);
        check("midrst.beats", 64'(req_beats), 64'd0);
        resp_valid = 1'b1;
        cycle();
        resp_valid = 1'b0;
        check("midrst.late_resp_err", 64'(err), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/leaf_refill_scheduler.md
Name: leaf_refill_scheduler

Overview:
- Sequences refills of the 2*L leaf input FIFOs that feed the merger tree from one shared memory read-request port.
- Holds per-leaf run pointers (base address, remaining length) loaded at pass setup.
- Tracks per-leaf free-slot credits against the tree's leaf reads, and round-robin arbitrates eligible leaves onto the request port.
- Signals pass completion once every run has been fully requested and all response beats have returned.

Parameters:
- NUM_LEAVES, 32, number of leaf FIFOs (2*L for L=16).
- LEAF_W, 5, width of a leaf index; equals log2(NUM_LEAVES).
- FIFO_DEPTH, 16, entries per leaf FIFO; the initial credit.
- BURST, 8, maximum items per request; must be ≤ FIFO_DEPTH.
- ADDR_W, 32, item-address width.
- LEN_W, 32, run-length width, in items.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_cfg_we  in  1  write one leaf's run descriptor; honoured only in IDLE.
- i_cfg_leaf  in  LEAF_W  leaf index for the descriptor.
- i_cfg_addr  in  ADDR_W  run start address, in items.
- i_cfg_len  in  LEN_W  run length, in items; 0 means the leaf is empty.
- i_start  in  1  begin a pass; honoured only in IDLE.
- i_leaf_read  in  NUM_LEAVES  per-leaf dequeue strobes, i.e. the tree's o_fifo_read.
- o_req_valid  out  1  memory read request valid.
- i_req_ready  in  1  memory accepts the request.
- o_req_addr  out  ADDR_W  request start item address.
- o_req_leaf  out  LEAF_W  destination leaf, carried as the request tag.
- o_req_beats  out  $clog2(BURST)+1  item count for the request, 1..BURST.
- i_resp_valid  in  1  one item returned; the item is written to its leaf FIFO externally.
- o_busy  out  1  pass in progress.
- o_done  out  1  one-cycle pulse at pass completion.
- o_err  out  1  sticky; a response arrived while the outstanding count was zero.

Behaviour:
- Reset values: o_req_valid=0, o_busy=0, o_done=0, o_err=0, all other outputs 0. All credits=FIFO_DEPTH, all remaining lengths=0, outstanding=0, RR pointer=0, state=IDLE.
- Reset mid-pass abandons all state immediately. Late responses arriving after reset set o_err.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN on i_start. If every remaining length is 0, go IDLE→DONE instead.
  - RUN→DRAIN when every remaining length is 0 and no request is pending.
  - DRAIN→DONE when outstanding==0.
  - DONE→IDLE after one cycle. o_done=1 only in DONE.
  - o_busy=1 in RUN and DRAIN.
- Eligibility of leaf l: remaining[l]>0 and credit[l] ≥ beats(l), where beats(l)=min(BURST, remaining[l]).
- Arbitration:
  - In RUN with no pending request, pick the first eligible leaf at or after the RR pointer, wrapping from NUM_LEAVES-1 to 0.
  - Register the request; o_req_valid rises the next cycle. Decision-to-valid latency is 1 cycle.
- Handshake:
  - While o_req_valid=1 and i_req_ready=0, o_req_addr, o_req_leaf and o_req_beats are held stable.
  - A request is never withdrawn except by reset.
- On acceptance (o_req_valid & i_req_ready) for leaf g:
  - addr[g] += beats; remaining[g] -= beats; credit[g] -= beats; outstanding += beats.
  - RR pointer ← g+1 (mod NUM_LEAVES).
  - o_req_valid falls the next cycle unless a new grant is registered in the same cycle. Back-to-back issue at one request per cycle is required.
- Credit return: each i_leaf_read[l]=1 adds 1 to credit[l].
  - If acceptance and a read hit the same leaf in one cycle, credit[g] = credit[g] − beats + 1.
  - Credit never exceeds FIFO_DEPTH. Reads arriving while credit==FIFO_DEPTH are ignored.
- Response: i_resp_valid decrements outstanding by 1. If outstanding==0, outstanding stays 0 and o_err is set.
  - Acceptance and response in the same cycle: outstanding += beats − 1.
- Final request of a run: when remaining < BURST, beats=remaining, so a run of 20 with BURST 8 issues 8, 8, 4.
- i_cfg_we and i_start outside IDLE are ignored with no side effect.

Decomposition:
- Shared package (merger_pkg): the NUM_LEAVES, FIFO_DEPTH and BURST constants, a leaf_idx_t typedef, and a run_desc_t struct {addr, len}.
- One sub-module, rr_arbiter: NUM_LEAVES-wide request vector plus a pointer in, one-hot grant plus grant index out, purely combinational.
- Credit and descriptor register arrays stay in the top module.

Test Plan:
- Single leaf: leaf 3 with addr 0x100, len 20; i_req_ready tied to 1; no reads.
  - Requests are (0x100, 8), then (0x108, 8), then a stall, since credit is 0.
  - After 4 reads on leaf 3, (0x110, 4) issues. After 20 responses, o_done pulses once.
- Round robin: leaves 0, 5 and 31 with len 8 each.
  - Grant order is 0, 5, 31 on consecutive cycles. The RR pointer then wraps to 0.
- Backpressure: hold i_req_ready=0 for 5 cycles after o_req_valid rises.
  - addr, leaf and beats are unchanged throughout, and exactly one acceptance occurs.
- Simultaneous events: leaf 2 credit 8, and in one cycle acceptance of 8 beats, i_leaf_read[2]=1 and i_resp_valid=1.
  - credit[2] becomes 1; outstanding increases by 7.
- Empty pass and errors:
  - i_start with all lengths 0: o_done pulses within 2 cycles and o_req_valid never rises.
  - i_resp_valid in IDLE sets o_err.
  - i_rst mid-pass: all outputs are 0 the next cycle.
- Ignored inputs: i_cfg_we and i_start asserted during RUN leave the descriptors and the pass unaffected.
